// File: rtl/cycle_meter_pkg.sv
// ============================================================================
// cycle_meter_pkg : shared state encoding, default sizes and pointer helper
// Revision 1.0
// ============================================================================
`default_nettype none

package cycle_meter_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_CNT_W = 30;
   localparam int DEF_DEPTH = 4;

   // Smallest r with 2**r >= value; used for FIFO address width.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_meter_fifo.sv
// ============================================================================
// cycle_meter_fifo : show-ahead result FIFO with wrap-bit pointers
// Revision 1.0
// ============================================================================
`default_nettype none

module cycle_meter_fifo
   import cycle_meter_pkg::*;
#(
   parameter int WIDTH = DEF_CNT_W + 1,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_rd_en;
   logic w_wr_en;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);

   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign w_rd_en = i_pop  && !w_empty && !i_clear;
   assign w_wr_en = i_push && (!w_full || w_rd_en) && !i_clear;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/cycle_meter.sv
// ============================================================================
// cycle_meter : start-to-done latency counter feeding a valid/ready result FIFO
// Optional min/max tracking with macro CYCLE_METER_MINMAX_EN. Revision 1.0
// ============================================================================
`default_nettype none

module cycle_meter
   import cycle_meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             start,
   input  logic             done,
   output logic [CNT_W-1:0] res_data,
   output logic             res_sat,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic             overflow
`ifdef CYCLE_METER_MINMAX_EN
   ,
   output logic [CNT_W-1:0] min_cycles,
   output logic [CNT_W-1:0] max_cycles
`endif
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_overflow;

   logic             w_sat;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_accept;
   logic [CNT_W:0]   w_head;

   assign w_sat    = (r_cnt == C_CNT_MAX);
   assign w_push   = (r_state == ST_RUN) && done && !clear;
   assign w_pop    = !w_empty && res_ready && !clear;
   assign w_accept = w_push && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (clear) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_RUN: begin
               if (done && start) begin
                  w_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
               end else if (done) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else if (!w_sat) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_overflow <= 1'b0;
      end else if (w_push && !w_accept) begin
         r_overflow <= 1'b1;
      end
   end

   cycle_meter_fifo #(
      .WIDTH (CNT_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clear (clear),
      .i_push  (w_push),
      .i_data  ({w_sat, r_cnt}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign res_sat   = w_head[CNT_W];
   assign res_data  = w_head[CNT_W-1:0];
   assign res_valid = !w_empty;
   assign busy      = (r_state == ST_RUN);
   assign overflow  = r_overflow;

`ifdef CYCLE_METER_MINMAX_EN
   logic [CNT_W-1:0] r_min;
   logic [CNT_W-1:0] r_max;

   // Only results that actually enter the FIFO are tracked.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_min <= '1;
         r_max <= '0;
      end else if (clear) begin
         r_min <= '1;
         r_max <= '0;
      end else if (w_accept) begin
         if (r_cnt < r_min) begin
            r_min <= r_cnt;
         end
         if (r_cnt > r_max) begin
            r_max <= r_cnt;
         end
      end
   end

   assign min_cycles = r_min;
   assign max_cycles = r_max;
`endif

endmodule

`default_nettype wire

// File: doc/cycle_meter.md
# cycle_meter

Measures the latency of a hardware accelerator run, such as the SHA256 HLS or VHDL core, in clock cycles. It watches the DUT's start and done strobes and runs a saturating cycle counter between them. Each measured latency is pushed into a small FIFO, and the results are read out over a valid/ready interface. It sits beside the DUT in the HLS-vs-VHDL comparison top level and feeds the result logger or VIO.

## Interface

Parameters:
- CNT_W, 30: counter and result width in bits.
- DEPTH, 4: result FIFO depth in entries. Must be a power of 2 and at least 2.

Ports:
- clk, in, 1: single clock. All logic is on its rising edge.
- rst, in, 1: asynchronous, active-low reset. Asserted when 0.
- clear, in, 1: synchronous soft clear. Has priority over all other inputs.
- start, in, 1: one-cycle strobe marking the DUT run start.
- done, in, 1: one-cycle strobe marking the DUT run completion.
- res_data, out, CNT_W: measured cycle count at the FIFO head.
- res_sat, out, 1: set if the head result saturated.
- res_valid, out, 1: FIFO is non-empty.
- res_ready, in, 1: consumer accepts the head result.
- busy, out, 1: a measurement is in progress (state RUN).
- overflow, out, 1: sticky flag; a result was dropped because the FIFO was full.

## Operation

- States: IDLE and RUN. Reset state is IDLE.
- IDLE:
  - start=1 moves to RUN and loads cnt to 1.
  - done is ignored.
- RUN:
  - cnt increments by 1 each cycle and saturates at all-ones. It never wraps.
  - done=1 pushes {sat, cnt} into the FIFO. sat is set when cnt is all-ones.
  - done=1 with start=0 returns to IDLE.
  - done=1 with start=1 pushes the result, stays in RUN and reloads cnt to 1 (back-to-back runs).
  - start=1 with done=0 is ignored. The current measurement continues.
- Elapsed count definition: start sampled at edge k and done sampled at edge k+N gives result N. The minimum result is 1.
- FIFO behaviour:
  - Show-ahead: res_data and res_sat are valid whenever res_valid=1.
  - Pop happens when res_valid and res_ready are both 1.
  - Push while full with no pop in the same cycle: the result is dropped and overflow is set.
  - Push while full with a pop in the same cycle: the push is accepted and overflow is not set.
  - Push while empty: res_valid rises on the next cycle. There is no bypass.
- clear=1:
  - State goes to IDLE and cnt to 0.
  - FIFO is emptied and overflow is cleared.
  - start, done and res_ready in the same cycle are ignored.

## Timing

- Reset values of outputs: res_valid=0, res_data=0, res_sat=0, busy=0, overflow=0. Internally, cnt=0 and the FIFO pointers are 0.
- busy rises 1 cycle after start is sampled in IDLE. It falls 1 cycle after done is sampled in RUN unless start was also high.
- Done to result latency: res_valid=1 the cycle after done, when the FIFO was empty.
- Output stability:
  - res_data and res_sat are held stable while res_valid=1 and res_ready=0.
  - res_valid never drops without a pop or a clear.
- Reset asserted mid-run: all state returns to reset values immediately. Any partial measurement is lost.
- Throughput: one result per cycle in, one per cycle out.

## Configuration

- Macro CYCLE_METER_MINMAX_EN.
- Defined:
  - Adds outputs min_cycles [CNT_W-1:0] and max_cycles [CNT_W-1:0].
  - Both are updated on every accepted push. Dropped results do not count.
  - Reset and clear values: min_cycles all-ones, max_cycles 0.
  - New values are visible the cycle after the push.
- Undefined: the ports and their registers are absent. All other behaviour is identical.

## Structure

- Package cycle_meter_pkg:
  - state encoding constants ST_IDLE and ST_RUN;
  - default CNT_W and DEPTH;
  - helper function clog2 for pointer width.
- Sub-module cycle_meter_fifo:
  - parameterised width (CNT_W+1) and DEPTH;
  - pointers with an extra wrap bit to distinguish full from empty;
  - push/pop/clear inputs and full/empty outputs;
  - same clk/rst convention as cycle_meter.
- The top level holds the FSM, the saturating counter, the overflow flag and the optional min/max logic.

## Test plan

- Basic run: start at cycle 10, done at cycle 15, res_ready=1. Expect res_valid at cycle 16 with res_data=5, res_sat=0, and busy high for cycles 11 to 15.
- Back-to-back runs: start at 0, then done and start together at 3, then done at 10. Expect results 3 then 7, and busy never falls between them.
- Saturation: with CNT_W=4, start, then done 20 cycles later. Expect res_data=15 and res_sat=1; the counter holds at 15 with no wrap.
- FIFO full: DEPTH=4, res_ready=0, five completed runs. Expect 4 entries held in order and overflow=1. Then clear: expect res_valid=0 and overflow=0 the next cycle.
- Simultaneous push and pop while full: done arrives while full and res_ready=1 in the same cycle. Expect the push accepted, overflow=0 and occupancy unchanged.
- Async reset mid-run: rst=0 for 1 cycle during RUN. Expect busy=0 and res_valid=0 at once, and no result produced by the later done. With CYCLE_METER_MINMAX_EN defined, results 5, 9, 2 give min=2, max=9.
